// File: rtl/la_muxi_pipe.sv
// Parametrised N-input binary-select mux with optional output inversion,
// delivered through a registered valid/ready stage backed by a one-entry skid register.
module la_muxi_pipe #(
    parameter int    N    = 3,
    parameter int    W    = 1,
    parameter int    SW   = 2,
    parameter int    INV  = 1,
    parameter string PROP = "DEFAULT"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N*W-1:0]   in,
    input  logic [SW-1:0]    sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    // Encoding is (out_valid, skid_valid) so both handshake outputs are plain register bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);
    localparam logic [W-1:0]  RST_DATA = (INV != 0) ? {W{1'b1}} : {W{1'b0}};

    generate
        if (N < 2 || (2 ** SW) < N) begin : g_bad_params
            $error("la_muxi_pipe: need N >= 2 and 2**SW >= N (N=%0d SW=%0d)", N, SW);
        end
        if (PROP != "DEFAULT") begin : g_prop_custom
            // PROP only carries implementation hints; it changes nothing here.
        end
    endgenerate

    logic [W-1:0]  in_arr_s [N];
    logic [SW-1:0] idx_s;
    logic          sel_sat_s;
    logic [W-1:0]  sel_data_s;
    logic [W-1:0]  pay_data_s;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          accept_s;
    logic          xfer_s;
    logic          load_main_in_s;
    logic          load_main_skid_s;
    logic          load_skid_s;

    logic [W-1:0]  main_data_r;
    logic          main_sat_r;
    logic [W-1:0]  skid_data_r;
    logic          skid_sat_r;

    genvar k;
    for (k = 0; k < N; k++) begin : g_unpack
        assign in_arr_s[k] = in[k*W +: W];
    end

    // Payload formation: saturating select plus optional inversion.
    always_comb begin
        sel_sat_s  = ({1'b0, sel} >= N_EXT);
        idx_s      = sel;
        if (sel_sat_s) begin
            idx_s = LAST_IDX;
        end else begin
            idx_s = sel;
        end
        sel_data_s = in_arr_s[idx_s];
        if (INV != 0) begin
            pay_data_s = ~sel_data_s;
        end else begin
            pay_data_s = sel_data_s;
        end
    end

    assign out_valid = state_r[1];
    assign in_ready  = ~state_r[0];
    assign accept_s  = in_valid & in_ready;
    assign xfer_s    = out_valid & out_ready;

    // Next-state and register-load decisions for the main/skid pair.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s    = ST_ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && xfer_s) begin
                    state_nxt_s    = ST_ONE;
                    load_main_in_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = ST_FULL;
                    load_skid_s = 1'b1;
                end else if (xfer_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (xfer_s) begin
                    state_nxt_s      = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Main output register: fresh payload, or the skid entry when draining from FULL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data_r <= RST_DATA;
            main_sat_r  <= 1'b0;
        end else if (load_main_in_s) begin
            main_data_r <= pay_data_s;
            main_sat_r  <= sel_sat_s;
        end else if (load_main_skid_s) begin
            main_data_r <= skid_data_r;
            main_sat_r  <= skid_sat_r;
        end
    end

    // Skid register: catches the beat accepted while the output is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_data_r <= RST_DATA;
            skid_sat_r  <= 1'b0;
        end else if (load_skid_s) begin
            skid_data_r <= pay_data_s;
            skid_sat_r  <= sel_sat_s;
        end
    end

    assign out     = main_data_r;
    assign out_sat = main_sat_r;

endmodule
